reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 116 +++++++++++
 tb/tb_reg_file_param.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file with self-initialisation,
// byte-enable writes, write-to-read bypass and registered reads.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic                     re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     rvalid,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wmerged;
  logic              wzero;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] ra      [NUM_RD];
  logic [DATA_W-1:0] rd_next [NUM_RD];

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int k = 0; k < NB; k++)
      if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  assign wzero   = (ZERO_REG != 0) && (waddr == '0);
  assign wr_en   = (state == RUN) && we && !wzero;
  assign rd_en   = (state == RUN) && re;
  assign wmerged = merge(mem[waddr], wdata, wbe);
  assign ready   = (state == RUN);

  // Controller: walk idx across the array, then stay in RUN.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (1'b1)
      (state == INIT): begin
        idx_nx = idx + 1'b1;
        if (&idx) state_nx = RUN;
      end
      default: ;
    endcase
  end

  // State and init index, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Array: init fill or byte-merged write; no reset, INIT rebuilds it.
  // While rst_n is low idx is 0, so only register 0 is rewritten with 0.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[idx] <= DATA_W'(idx);
    else if (wr_en)
      mem[waddr] <= wmerged;
  end

  // Per-port read mux with same-edge bypass and zero-register mask.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p]      = raddr[p*ADDR_W +: ADDR_W];
      rd_next[p] = mem[ra[p]];
      if (wr_en && (waddr == ra[p]))
        rd_next[p] = wmerged;
      if ((ZERO_REG != 0) && (ra[p] == '0))
        rd_next[p] = '0;
    end
  end

  // Registered read data and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en)
        for (int p = 0; p < NUM_RD; p++)
          rdata[p*DATA_W +: DATA_W] <= rd_next[p];
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param with default parameters.
// Inputs change 1ns after rising edges; outputs checked there too.
module tb_reg_file_param;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  reg_file_param #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .re(re), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    wbe   = '0;
    re    = 1'b1;
    raddr = {5'd3, 5'd2};
    #2;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("init_ready_%0d", i),
            64'(ready), 64'(i == 32));
      check($sformatf("init_rvalid_%0d", i),
            64'(rvalid), 64'd0);
    end
    step();
    check("first_rd_p0", 64'(rdata[31:0]), 64'd2);
    check("first_rd_p1", 64'(rdata[63:32]), 64'd3);
    check("first_rvalid", 64'(rvalid), 64'd1);

    we = 1'b1; waddr = 5'd4; wdata = 32'd16; wbe = 4'hF;
    re = 1'b0;
    step();
    check("no_re_rvalid", 64'(rvalid), 64'd0);
    we = 1'b0; re = 1'b1; raddr = {5'd4, 5'd4};
    step();
    check("wr4_p0", 64'(rdata[31:0]), 64'd16);
    check("wr4_p1", 64'(rdata[63:32]), 64'd16);
    check("wr4_rvalid", 64'(rvalid), 64'd1);

    re = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_p0_%0d", i),
            64'(rdata[31:0]), 64'd16);
      check($sformatf("hold_rvalid_%0d", i),
            64'(rvalid), 64'd0);
    end

    we = 1'b1; waddr = 5'd7; wdata = 32'hAABBCCDD;
    wbe = 4'b0101; re = 1'b1; raddr = {5'd0, 5'd7};
    step();
    check("byp7_p0", 64'(rdata[31:0]), 64'h00BB00DD);
    check("byp7_p1", 64'(rdata[63:32]), 64'd0);
    we = 1'b0; raddr = {5'd7, 5'd7};
    step();
    check("rd7_p0", 64'(rdata[31:0]), 64'h00BB00DD);
    check("rd7_p1", 64'(rdata[63:32]), 64'h00BB00DD);

    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    wbe = 4'hF; raddr = {5'd0, 5'd0};
    step();
    check("z_same_p0", 64'(rdata[31:0]), 64'd0);
    check("z_same_p1", 64'(rdata[63:32]), 64'd0);
    we = 1'b0;
    step();
    check("z_next_p0", 64'(rdata[31:0]), 64'd0);
    check("z_next_p1", 64'(rdata[63:32]), 64'd0);
    check("z_next_rvalid", 64'(rvalid), 64'd1);

    we = 1'b1; waddr = 5'd4; wdata = 32'h0000FFFF;
    wbe = 4'h0; raddr = {5'd5, 5'd4};
    step();
    check("be0_p0", 64'(rdata[31:0]), 64'd16);
    check("be0_p1", 64'(rdata[63:32]), 64'd5);

    waddr = 5'd9; wdata = 32'h12345678;
    wbe = 4'b1000; raddr = {5'd9, 5'd9};
    step();
    check("byp9_p0", 64'(rdata[31:0]), 64'h12000009);
    check("byp9_p1", 64'(rdata[63:32]), 64'h12000009);
    we = 1'b0;

    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_rdata", rdata, 64'd0);
    step();
    step();
    we = 1'b1; waddr = 5'd30; wdata = 32'h0000DEAD;
    wbe = 4'hF; re = 1'b1; raddr = {5'd30, 5'd4};
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("reinit_ready_%0d", i),
            64'(ready), 64'(i == 32));
      check($sformatf("reinit_rvalid_%0d", i),
            64'(rvalid), 64'd0);
    end
    check("reinit_rdata", rdata, 64'd0);
    we = 1'b0;
    step();
    check("reinit_p0", 64'(rdata[31:0]), 64'd4);
    check("reinit_p1", 64'(rdata[63:32]), 64'd30);
    check("reinit_rvalid", 64'(rvalid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
